// File: rtl/output_writer_pkg.sv
// Shared definitions for the kernel router / output writer pair:
// FSM state encodings, default datapath widths and requantisation limits.
package output_writer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } stateT;

  localparam int DATA_WIDTH = 8;
  localparam int ACC_WIDTH  = 20;
  localparam int SAT_MAX    = 127;
  localparam int SAT_MIN    = -128;

endpackage

// File: rtl/output_writer_requant_lane.sv
// Requantises one signed accumulator lane to a buffer word:
// arithmetic shift, optional ReLU, then saturation to the signed byte range.
module requant_lane
  import output_writer_pkg::*;
#(
  parameter int AccWidth  = ACC_WIDTH,
  parameter int DataWidth = DATA_WIDTH
) (
  input  logic signed [AccWidth-1:0]  laneIn,
  input  logic        [3:0]           shift,
  input  logic                        reluEn,
  output logic        [DataWidth-1:0] dataOut,
  output logic                        sat
);

  localparam logic signed [AccWidth-1:0] MaxVal = AccWidth'(SAT_MAX);
  localparam logic signed [AccWidth-1:0] MinVal = AccWidth'(SAT_MIN);

  logic signed [AccWidth-1:0] shifted;
  logic signed [AccWidth-1:0] clamped;

  // ReLU happens before saturation, so zeroing a negative never counts as a clip.
  always_comb begin
    shifted = laneIn >>> shift;
    clamped = shifted;
    if (reluEn && shifted[AccWidth-1]) clamped = '0;
    sat     = 1'b0;
    dataOut = clamped[DataWidth-1:0];
    if (clamped > MaxVal) begin
      dataOut = MaxVal[DataWidth-1:0];
      sat     = 1'b1;
    end else if (clamped < MinVal) begin
      dataOut = MinVal[DataWidth-1:0];
      sat     = 1'b1;
    end
  end

endmodule

// File: rtl/output_writer.sv
// Write-side partner of the kernel router: accepts beats of accumulator lanes,
// requantises them and writes one byte per cycle into the output buffer.
module output_writer
  import output_writer_pkg::*;
#(
  parameter int NumLanes   = 4,
  parameter int AccWidth   = ACC_WIDTH,
  parameter int DataWidth  = DATA_WIDTH,
  parameter int Depth      = 32,
  parameter int AddrWidth  = $clog2(Depth),
  parameter int CountWidth = 2*AddrWidth,
  parameter int LaneWidth  = $clog2(NumLanes+1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         startEn,
  input  logic [AddrWidth-1:0]         baseAddr,
  input  logic [AddrWidth-1:0]         outputWidth,
  input  logic [3:0]                   shift,
  input  logic                         reluEn,
  input  logic                         resultValid,
  output logic                         resultReady,
  input  logic [NumLanes*AccWidth-1:0] resultIn,
  input  logic [LaneWidth-1:0]         resultCount,
  output logic                         writeEn,
  output logic [AddrWidth-1:0]         writeAddr,
  output logic [DataWidth-1:0]         dataOut,
  output logic                         busy,
  output logic                         finished,
  output logic                         satFlag,
  output logic [1:0]                   state
);

  stateT                       stateQ, stateD;
  logic [AddrWidth-1:0]        baseQ;
  logic [3:0]                  shiftQ;
  logic                        reluQ;
  logic [CountWidth-1:0]       totalQ, writtenQ, remaining;
  logic [NumLanes*AccWidth-1:0] laneRegQ;
  logic [LaneWidth-1:0]        laneCntQ, laneIdxQ, beatCount, trimmedCount;
  logic                        lastLane;
  logic signed [AccWidth-1:0]  laneSel;
  logic [DataWidth-1:0]        laneData;
  logic                        laneSat;

  // A zero or oversized count means a full beat; never write past the job total.
  always_comb begin
    beatCount = resultCount;
    if (resultCount == '0 || resultCount > LaneWidth'(NumLanes))
      beatCount = LaneWidth'(NumLanes);
    remaining    = totalQ - writtenQ;
    trimmedCount = beatCount;
    if (CountWidth'(beatCount) > remaining)
      trimmedCount = remaining[LaneWidth-1:0];
  end

  assign lastLane = (laneIdxQ == laneCntQ - LaneWidth'(1));
  assign laneSel  = laneRegQ[laneIdxQ*AccWidth +: AccWidth];

  requant_lane #(
    .AccWidth (AccWidth),
    .DataWidth(DataWidth)
  ) uRequant (
    .laneIn (laneSel),
    .shift  (shiftQ),
    .reluEn (reluQ),
    .dataOut(laneData),
    .sat    (laneSat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stateQ <= IDLE;
    else      stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE, DONE: if (startEn) stateD = (outputWidth == '0) ? DONE : ACCEPT;
      ACCEPT:     if (resultValid) stateD = WRITE;
      WRITE:      if (lastLane)
                    stateD = (writtenQ + CountWidth'(1) == totalQ) ? DONE : ACCEPT;
      default:    stateD = IDLE;
    endcase
  end

  // Address wraps by truncation, which matches mod Depth for power-of-two depths.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baseQ     <= '0;
      shiftQ    <= '0;
      reluQ     <= 1'b0;
      totalQ    <= '0;
      writtenQ  <= '0;
      laneRegQ  <= '0;
      laneCntQ  <= '0;
      laneIdxQ  <= '0;
      writeEn   <= 1'b0;
      writeAddr <= '0;
      dataOut   <= '0;
      finished  <= 1'b0;
      satFlag   <= 1'b0;
    end else begin
      writeEn <= 1'b0;
      case (stateQ)
        IDLE, DONE: if (startEn) begin
          baseQ    <= baseAddr;
          shiftQ   <= shift;
          reluQ    <= reluEn;
          totalQ   <= CountWidth'(outputWidth) * CountWidth'(outputWidth);
          writtenQ <= '0;
          satFlag  <= 1'b0;
          finished <= (outputWidth == '0);
        end
        ACCEPT: if (resultValid) begin
          laneRegQ <= resultIn;
          laneCntQ <= trimmedCount;
          laneIdxQ <= '0;
        end
        WRITE: begin
          writeEn   <= 1'b1;
          writeAddr <= baseQ + writtenQ[AddrWidth-1:0];
          dataOut   <= laneData;
          satFlag   <= satFlag | laneSat;
          writtenQ  <= writtenQ + CountWidth'(1);
          laneIdxQ  <= laneIdxQ + LaneWidth'(1);
          if (stateD == DONE) finished <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign resultReady = (stateQ == ACCEPT);
  assign busy        = (stateQ == ACCEPT) || (stateQ == WRITE);
  assign state       = stateQ;

endmodule

// File: tb/tb_output_writer.sv
// Self-checking bench for output_writer: directed and random jobs compared
// against a flat lane-stream reference model of the requantise-and-write rules.
module tb_output_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        startEn = 1'b0;
  logic [4:0]  baseAddr = '0;
  logic [4:0]  outputWidth = '0;
  logic [3:0]  shift = '0;
  logic        reluEn = 1'b0;
  logic        resultValid = 1'b0;
  logic        resultReady;
  logic [79:0] resultIn = '0;
  logic [2:0]  resultCount = '0;
  logic        writeEn;
  logic [4:0]  writeAddr;
  logic [7:0]  dataOut;
  logic        busy, finished, satFlag;
  logic [1:0]  state;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  logic [79:0] beatData[$];
  int          beatCnt[$];
  int          acceptQ[$];
  int          wAddr[$];
  int          wData[$];
  int          wCyc[$];

  output_writer dut (
    .clk(clk), .rst(rst), .startEn(startEn), .baseAddr(baseAddr),
    .outputWidth(outputWidth), .shift(shift), .reluEn(reluEn),
    .resultValid(resultValid), .resultReady(resultReady), .resultIn(resultIn),
    .resultCount(resultCount), .writeEn(writeEn), .writeAddr(writeAddr),
    .dataOut(dataOut), .busy(busy), .finished(finished), .satFlag(satFlag),
    .state(state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (writeEn) begin
      wAddr.push_back(int'(writeAddr));
      wData.push_back(int'(dataOut));
      wCyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int effCount(input int c);
    return (c == 0 || c > 4) ? 4 : c;
  endfunction

  function automatic int requantRef(input int lane, input int sh, input bit relu, output bit clip);
    int v;
    v = lane >>> sh;
    clip = 1'b0;
    if (relu && v < 0) v = 0;
    if (v > 127) begin v = 127; clip = 1'b1; end
    if (v < -128) begin v = -128; clip = 1'b1; end
    return v & 8'hFF;
  endfunction

  function automatic logic [79:0] packLanes(input int a, input int b, input int c, input int d);
    logic [79:0] r;
    r[19:0]  = 20'(a);
    r[39:20] = 20'(b);
    r[59:40] = 20'(c);
    r[79:60] = 20'(d);
    return r;
  endfunction

  task automatic addBeat(input logic [79:0] d, input int c);
    beatData.push_back(d);
    beatCnt.push_back(c);
  endtask

  task automatic genBeats(input int total);
    int need;
    logic [79:0] d;
    need = total;
    while (need > 0) begin
      for (int k = 0; k < 4; k++)
        d[k*20 +: 20] = ($urandom_range(0, 2) == 0) ? 20'($urandom) : 20'($urandom_range(0, 600) - 300);
      addBeat(d, $urandom_range(0, 7));
      need -= effCount(beatCnt[beatCnt.size()-1]);
    end
  endtask

  task automatic runJob(input string tag, input int base, input int ow, input int sh,
                        input bit relu, input bit gaps);
    int timeout, total, idx, n, lane, ed;
    bit clip, expSat;
    int expAddr[$], expData[$], expCyc[$];
    logic [79:0] bd;
    wAddr.delete(); wData.delete(); wCyc.delete(); acceptQ.delete();
    @(negedge clk);
    baseAddr = 5'(base); outputWidth = 5'(ow); shift = 4'(sh); reluEn = relu; startEn = 1'b1;
    @(negedge clk);
    startEn = 1'b0;
    for (int b = 0; b < beatData.size(); b++) begin
      if (gaps) begin
        resultValid = 1'b0;
        repeat ($urandom_range(0, 5)) @(negedge clk);
      end
      resultIn = beatData[b]; resultCount = 3'(beatCnt[b]); resultValid = 1'b1;
      timeout = 0;
      while (!resultReady && timeout < 100) begin @(negedge clk); timeout++; end
      if (!resultReady) begin
        check({tag, ".acceptTimeout"}, 32'(resultReady), 32'd1);
        break;
      end
      @(posedge clk); #1;
      acceptQ.push_back(cyc);
      check($sformatf("%s.readyInWrite%0d", tag, b), 32'(resultReady), 32'd0);
      @(negedge clk);
    end
    resultValid = 1'b0;
    timeout = 0;
    while (!finished && timeout < 200) begin @(negedge clk); timeout++; end
    check({tag, ".finished"}, 32'(finished), 32'd1);
    repeat (2) @(negedge clk);

    total = ow * ow; idx = 0; expSat = 1'b0;
    for (int b = 0; b < beatData.size(); b++) begin
      bd = beatData[b];
      n = effCount(beatCnt[b]);
      for (int k = 0; k < n; k++) begin
        if (idx < total) begin
          lane = $signed(bd[k*20 +: 20]);
          ed = requantRef(lane, sh, relu, clip);
          expSat |= clip;
          expAddr.push_back((base + idx) % 32);
          expData.push_back(ed);
          expCyc.push_back((b < acceptQ.size()) ? acceptQ[b] + 1 + k : -1);
          idx++;
        end
      end
    end
    check({tag, ".writeCount"}, 32'(wAddr.size()), 32'(expAddr.size()));
    for (int i = 0; i < expAddr.size() && i < wAddr.size(); i++) begin
      check($sformatf("%s.addr%0d", tag, i), 32'(wAddr[i]), 32'(expAddr[i]));
      check($sformatf("%s.data%0d", tag, i), 32'(wData[i]), 32'(expData[i]));
      check($sformatf("%s.cycle%0d", tag, i), 32'(wCyc[i]), 32'(expCyc[i]));
    end
    check({tag, ".satFlag"}, 32'(satFlag), 32'(expSat));
    check({tag, ".stateDone"}, 32'(state), 32'd3);
    check({tag, ".busyDone"}, 32'(busy), 32'd0);
    beatData.delete(); beatCnt.delete();
  endtask

  initial begin
    int ow;
    rst = 1'b0;
    #2;
    check("reset.writeEn", 32'(writeEn), 32'd0);
    check("reset.writeAddr", 32'(writeAddr), 32'd0);
    check("reset.dataOut", 32'(dataOut), 32'd0);
    check("reset.ready", 32'(resultReady), 32'd0);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.finished", 32'(finished), 32'd0);
    check("reset.satFlag", 32'(satFlag), 32'd0);
    check("reset.state", 32'(state), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    addBeat(packLanes(5, -3, 100, 7), 4);
    runJob("basic", 4, 2, 0, 1'b0, 1'b0);

    addBeat(packLanes(1000, -40, 511, -1), 4);
    runJob("reluSat", 0, 2, 2, 1'b1, 1'b0);

    for (int b = 0; b < 3; b++) addBeat(packLanes(10*b+1, 10*b+2, 10*b+3, 10*b+4), 4);
    runJob("drop", 8, 3, 0, 1'b0, 1'b0);

    addBeat(packLanes(-200, 300, 64, -64), 4);
    runJob("wrap", 30, 2, 1, 1'b0, 1'b0);

    addBeat(packLanes(1, 2, 3, 4), 2);
    addBeat(packLanes(5, 6, 7, 8), 1);
    addBeat(packLanes(9, 10, 11, 12), 0);
    addBeat(packLanes(13, 14, 15, 16), 3);
    runJob("stall", 12, 3, 0, 1'b0, 1'b1);

    runJob("zeroWidth", 3, 0, 0, 1'b0, 1'b0);

    // Reset while lane 1 of a beat is being produced.
    @(negedge clk);
    baseAddr = 5'd0; outputWidth = 5'd2; shift = 4'd0; reluEn = 1'b0; startEn = 1'b1;
    @(negedge clk);
    startEn = 1'b0;
    resultIn = packLanes(1, 2, 3, 4); resultCount = 3'd4; resultValid = 1'b1;
    for (int t = 0; t < 20 && !resultReady; t++) @(negedge clk);
    @(posedge clk); #1;
    resultValid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midReset.writeEn", 32'(writeEn), 32'd0);
    check("midReset.state", 32'(state), 32'd0);
    check("midReset.finished", 32'(finished), 32'd0);
    check("midReset.busy", 32'(busy), 32'd0);
    wAddr.delete(); wData.delete(); wCyc.delete();
    repeat (3) @(negedge clk);
    check("midReset.noWrites", 32'(wAddr.size()), 32'd0);
    rst = 1'b1;
    addBeat(packLanes(-7, 8, -9, 10), 4);
    runJob("afterReset", 20, 2, 0, 1'b1, 1'b0);

    for (int j = 0; j < 6; j++) begin
      ow = $urandom_range(1, 5);
      genBeats(ow * ow);
      runJob($sformatf("rand%0d", j), $urandom_range(0, 31), ow, $urandom_range(0, 15),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
